// File: rtl/jk_driver.sv
// jk_driver: turns target state words into J/K excitation for an external JK
// flip-flop bank, verifies the bank through Q feedback and retries on mismatch.

module jk_exc_lane #(
  parameter bit USE_TOGGLE = 1'b1
) (
  input  logic t_i,
  input  logic qb_i,
  output logic j_o,
  output logic k_o
);
  // Toggle mode only excites bits that differ; set/reset mode always forces.
  assign j_o = USE_TOGGLE ? (t_i ^ qb_i) : t_i;
  assign k_o = USE_TOGGLE ? (t_i ^ qb_i) : ~t_i;
endmodule

module jk_driver #(
  parameter int N          = 4,
  parameter bit USE_TOGGLE = 1'b1,
  parameter int MAX_RETRY  = 2
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] target,
  output logic [N-1:0] j,
  output logic [N-1:0] k,
  input  logic [N-1:0] q,
  output logic         done,
  output logic         err,
  output logic [N-1:0] err_mask
);
  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_e;

  localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRY);

  state_e       state_q;
  logic [N-1:0] target_q, j_q, k_q, mask_q;
  logic [N-1:0] tsel, j_d, k_d;
  logic [2:0]   retry_q;
  logic         done_q, err_q;

  // On accept the live target is used; on retry the captured one.
  assign tsel = (state_q == IDLE) ? target : target_q;

  for (genvar b = 0; b < N; b++) begin : g_lane
    jk_exc_lane #(.USE_TOGGLE(USE_TOGGLE)) u_lane (
      .t_i (tsel[b]),
      .qb_i(q[b]),
      .j_o (j_d[b]),
      .k_o (k_d[b])
    );
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      target_q <= '0;
      j_q      <= '0;
      k_q      <= '0;
      mask_q   <= '0;
      retry_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      // j/k are only ever held for a single DRIVE cycle, so a stuck toggle
      // cannot keep the bank oscillating.
      done_q <= 1'b0;
      err_q  <= 1'b0;
      j_q    <= '0;
      k_q    <= '0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q  <= DRIVE;
            target_q <= target;
            j_q      <= j_d;
            k_q      <= k_d;
            mask_q   <= '0;
            retry_q  <= '0;
          end
        end
        DRIVE: state_q <= CHECK;
        CHECK: begin
          if (q == target_q) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else if (retry_q < RETRY_MAX) begin
            state_q <= DRIVE;
            retry_q <= retry_q + 3'd1;
            j_q     <= j_d;
            k_q     <= k_d;
          end else begin
            state_q <= IDLE;
            err_q   <= 1'b1;
            mask_q  <= q ^ target_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready = (state_q == IDLE);
  assign j        = j_q;
  assign k        = k_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_mask = mask_q;
endmodule

// File: tb/tb_jk_driver.sv
// Bench for jk_driver: two instances (toggle and set/reset excitation) each
// drive their own behavioural JK bank and are checked against a transaction model.
module tb_jk_driver;
  localparam int N    = 4;
  localparam int MAXR = 2;

  logic         clock   = 1'b0;
  logic         reset_n = 1'b1;
  logic         in_valid;
  logic [N-1:0] target;
  logic [N-1:0] jw [2];
  logic [N-1:0] kw [2];
  logic [N-1:0] mw [2];
  logic [N-1:0] bq [2];
  logic         rdy [2];
  logic         dn [2];
  logic         er [2];
  logic         bank_ld;
  logic [N-1:0] bank_val;
  logic [N-1:0] stuck0;
  int           n_checks = 0;
  int           n_err    = 0;

  always #5 clock = ~clock;

  jk_driver #(.N(N), .USE_TOGGLE(1'b1), .MAX_RETRY(MAXR)) u_tog (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy[0]),
    .target(target), .j(jw[0]), .k(kw[0]), .q(bq[0]),
    .done(dn[0]), .err(er[0]), .err_mask(mw[0])
  );

  jk_driver #(.N(N), .USE_TOGGLE(1'b0), .MAX_RETRY(MAXR)) u_sr (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy[1]),
    .target(target), .j(jw[1]), .k(kw[1]), .q(bq[1]),
    .done(dn[1]), .err(er[1]), .err_mask(mw[1])
  );

  // JK bank: Q+ = J&~Q | ~K&Q, with optional stuck-at-0 bits.
  always @(posedge clock) begin
    for (int i = 0; i < 2; i++)
      bq[i] <= bank_ld ? (bank_val & ~stuck0)
                       : (((jw[i] & ~bq[i]) | (~kw[i] & bq[i])) & ~stuck0);
  end

  function automatic logic [2*N-1:0] exc(input bit tog, input logic [N-1:0] t,
                                         input logic [N-1:0] qb);
    if (tog) return {t ^ qb, t ^ qb};
    return {t, ~t};
  endfunction

  // Transaction model: m_step counts edges since accept; even steps are drive
  // cycles, odd steps are check cycles, attempts made = (m_step+1)/2.
  bit           m_busy [2];
  int           m_step [2];
  logic [N-1:0] m_tgt  [2];
  logic [N-1:0] e_j    [2];
  logic [N-1:0] e_k    [2];
  logic [N-1:0] e_mask [2];
  logic         e_done [2];
  logic         e_err  [2];

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i] <= 1'b0; m_step[i] <= 0; m_tgt[i] <= '0;
        e_j[i] <= '0; e_k[i] <= '0; e_mask[i] <= '0;
        e_done[i] <= 1'b0; e_err[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        e_done[i] <= 1'b0; e_err[i] <= 1'b0; e_j[i] <= '0; e_k[i] <= '0;
        if (!m_busy[i]) begin
          if (in_valid) begin
            m_busy[i] <= 1'b1; m_step[i] <= 0; m_tgt[i] <= target; e_mask[i] <= '0;
            {e_j[i], e_k[i]} <= exc(i == 0, target, bq[i]);
          end
        end else begin
          m_step[i] <= m_step[i] + 1;
          if (m_step[i] % 2 == 1) begin
            if (bq[i] == m_tgt[i]) begin
              m_busy[i] <= 1'b0; e_done[i] <= 1'b1;
            end else if ((m_step[i] + 1) / 2 <= MAXR) begin
              {e_j[i], e_k[i]} <= exc(i == 0, m_tgt[i], bq[i]);
            end else begin
              m_busy[i] <= 1'b0; e_err[i] <= 1'b1; e_mask[i] <= bq[i] ^ m_tgt[i];
            end
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  logic prev_jk [2] = '{1'b0, 1'b0};

  task automatic cmp_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("j%0d", i), jw[i], e_j[i]);
      chk($sformatf("k%0d", i), kw[i], e_k[i]);
      chk($sformatf("done%0d", i), dn[i], e_done[i]);
      chk($sformatf("err%0d", i), er[i], e_err[i]);
      chk($sformatf("err_mask%0d", i), mw[i], e_mask[i]);
      chk($sformatf("in_ready%0d", i), rdy[i], !m_busy[i]);
      chk($sformatf("jk_consec%0d", i), prev_jk[i] && ((jw[i] & kw[i]) != '0), 1'b0);
      prev_jk[i] = ((jw[i] & kw[i]) != '0);
    end
  endtask

  task automatic step();
    @(negedge clock);
    cmp_all();
  endtask

  task automatic load_bank(input logic [N-1:0] v);
    bank_ld = 1'b1; bank_val = v;
    step();
    bank_ld = 1'b0;
  endtask

  int           drives, err_at, dn_seen, idx, n_done;
  int           acc_cyc [3];
  logic         acc;
  logic [N-1:0] tv [3];

  initial begin
    in_valid = 1'b0; target = '0; bank_ld = 1'b0; bank_val = '0; stuck0 = '0;
    #1 reset_n = 1'b0;
    step(); step();
    chk("rst_ready", rdy[0], 1'b1);
    chk("rst_jk", {jw[0], kw[0]}, 8'h00);
    chk("rst_done_err", {dn[0], er[0]}, 2'b00);
    chk("rst_mask", mw[0], 4'b0000);
    reset_n = 1'b1;

    // Toggle: q=1111 -> 1010
    load_bank(4'b1111);
    in_valid = 1'b1; target = 4'b1010;
    step(); in_valid = 1'b0;
    chk("t1_j", jw[0], 4'b0101);
    chk("t1_k", kw[0], 4'b0101);
    chk("t1_sr_j", jw[1], 4'b1010);
    chk("t1_sr_k", kw[1], 4'b0101);
    step();
    chk("t1_q", bq[0], 4'b1010);
    chk("t1_jk_idle", {jw[0], kw[0]}, 8'h00);
    chk("t1_no_done", dn[0], 1'b0);
    step();
    chk("t1_done", dn[0], 1'b1);
    chk("t1_ready", rdy[0], 1'b1);
    step();
    chk("t1_done_pulse", dn[0], 1'b0);

    // Set/reset: q=0000 -> 0110
    load_bank(4'b0000);
    in_valid = 1'b1; target = 4'b0110;
    step(); in_valid = 1'b0;
    chk("t2_sr_j", jw[1], 4'b0110);
    chk("t2_sr_k", kw[1], 4'b1001);
    step();
    chk("t2_sr_jk_idle", {jw[1], kw[1]}, 8'h00);
    step();
    chk("t2_sr_done", dn[1], 1'b1);
    chk("t2_sr_q", bq[1], 4'b0110);

    // Bit 2 stuck at 0: three drives, err six cycles after accept
    stuck0 = 4'b0100;
    load_bank(4'b0000);
    in_valid = 1'b1; target = 4'b0100;
    step(); in_valid = 1'b0;
    drives = 0; err_at = -1; dn_seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) step();
      if ((jw[0] | kw[0]) != '0) drives++;
      if (er[0] && err_at < 0) err_at = c;
      if (dn[0] || dn[1]) dn_seen++;
    end
    chk("t3_drives", drives, 3);
    chk("t3_err_at", err_at, 6);
    chk("t3_no_done", dn_seen, 0);
    chk("t3_mask_held", mw[0], 4'b0100);
    chk("t3_sr_mask_held", mw[1], 4'b0100);
    stuck0 = '0;

    // Back-to-back stream with in_valid held high
    load_bank(4'b0000);
    tv[0] = 4'b0001; tv[1] = 4'b0011; tv[2] = 4'b0000;
    idx = 0; n_done = 0;
    for (int a = 0; a < 3; a++) acc_cyc[a] = -100;
    in_valid = 1'b1; target = tv[0];
    for (int c = 0; c < 20 && n_done < 3; c++) begin
      acc = rdy[0] && in_valid;
      step();
      if (dn[0]) n_done++;
      if (acc && idx < 3) begin
        acc_cyc[idx] = c; idx++;
        if (idx < 3) target = tv[idx];
        else in_valid = 1'b0;
      end
    end
    chk("t4_done_count", n_done, 3);
    chk("t4_gap01", acc_cyc[1] - acc_cyc[0], 3);
    chk("t4_gap12", acc_cyc[2] - acc_cyc[1], 3);
    chk("t4_final_q", bq[0], 4'b0000);

    // in_valid during DRIVE/CHECK is ignored
    in_valid = 1'b1; target = 4'b0011;
    step(); target = 4'b1100;
    step(); step(); in_valid = 1'b0;
    chk("t5_done", dn[0], 1'b1);
    chk("t5_q", bq[0], 4'b0011);
    step();
    chk("t5_idle", rdy[0], 1'b1);

    // Asynchronous reset mid-DRIVE
    in_valid = 1'b1; target = 4'b1100;
    step(); in_valid = 1'b0;
    chk("t6_driving", jw[0], 4'b1111);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_jk", {jw[0], kw[0], jw[1], kw[1]}, 16'h0000);
    chk("t6_rst_done_err", {dn[0], er[0], dn[1], er[1]}, 4'b0000);
    chk("t6_rst_ready", {rdy[0], rdy[1]}, 2'b11);
    step();
    reset_n = 1'b1;
    chk("t6_q_held", bq[0], 4'b0011);
    in_valid = 1'b1; target = 4'b1001;
    step(); in_valid = 1'b0;
    step(); step();
    chk("t6_done", dn[0], 1'b1);
    chk("t6_q", bq[0], 4'b1001);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
